stack_cpu: RTL and testbench
============================

# stack_cpu

Parametrised multicycle stack-machine core, successor to the fixed 8-bit stack processor top. It keeps the same eight-opcode stack ISA and the push/pop/tos stack model. New in this generation:
- configurable data width and stack depth
- an external memory port with a req/ready wait-state handshake
- stack overflow/underflow detection

It sits between a unified instruction/data memory and the system top, and is the only bus master.

## Interface
- WIDTH, 8, data and instruction word width; ADDR_W = WIDTH-3 derived, ≥ 2
- STACK_DEPTH, 16, number of stack entries, ≥ 2; SP_W = $clog2(STACK_DEPTH+1) derived
- clk  input  1  single clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- mem_req  output  1  memory transfer request
- mem_we  output  1  1 = write, 0 = read; valid with mem_req
- mem_addr  output  ADDR_W  word address
- mem_wdata  output  WIDTH  write data
- mem_ready  input  1  transfer completes on the clock edge where mem_req && mem_ready
- mem_rdata  input  WIDTH  read data; valid when mem_ready = 1
- fault  output  1  sticky stack-error flag
- sp  output  SP_W  current stack occupancy
- pc  output  ADDR_W  current program counter

## Operation
- Instruction format: [WIDTH-1:WIDTH-3] opcode, [ADDR_W-1:0] address.
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 NOT
  - 100 PUSH addr: push mem[addr]
  - 101 POP addr: mem[addr] ← pop
  - 110 JMP addr
  - 111 JZ addr: if tos == 0 then pc ← addr; tos is not popped
- Operand naming: A = first popped value (top of stack), B = second popped value.
  - ADD pushes B+A; SUB pushes B−A; AND pushes B&A; NOT pops A and pushes ~A.
  - All arithmetic is modulo 2^WIDTH; there are no flags.
- State machine:
  - START → FETCH
  - FETCH (read at pc; on ready: IR ← rdata, pc ← pc+1) → DECODE
  - DECODE dispatches:
    - JMP: pc ← addr → FETCH
    - JZ: conditional pc update → FETCH
    - PUSH → MEM_RD
    - POP, NOT, binary ops → POP_A
  - POP_A (A ← tos, sp−1):
    - POP → MEM_WR
    - NOT → EXEC
    - binary ops → POP_B
  - POP_B (B ← tos, sp−1) → EXEC
  - EXEC (push result, sp+1) → FETCH
  - MEM_RD (read at addr; on ready push rdata) → FETCH
  - MEM_WR (write A to addr; on ready) → FETCH
  - FAULT is absorbing.
- Stack checks, all performed in DECODE before any state change:
  - binary op with sp < 2 → FAULT
  - NOT, POP or JZ with sp == 0 → FAULT
  - PUSH with sp == STACK_DEPTH → FAULT
- Handshake rules:
  - mem_req = 1 only in FETCH, MEM_RD and MEM_WR.
  - mem_addr, mem_we and mem_wdata are held stable while mem_req = 1 and mem_ready = 0.
  - mem_ready is ignored while mem_req = 0.

## Timing
- Reset values (asynchronous, while rst = 1): state START, pc 0, sp 0, fault 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0.
- The first mem_req is asserted one cycle after rst is released.
- Zero-wait latencies (cycles from FETCH entry to the next FETCH entry): JMP/JZ 2, PUSH 3, POP/NOT 4, ADD/SUB/AND 5. Each wait cycle on mem_ready adds 1.
- rst asserted mid-transfer aborts the transfer; mem_req drops in the same cycle, asynchronously.
- fault rises on the edge that leaves DECODE. In FAULT, mem_req = 0, and pc and sp are frozen until rst.

## Configuration
- STACK_CPU_GUARD_EN defined: stack checks and the FAULT state exist, as described above.
- STACK_CPU_GUARD_EN undefined: fault is tied to 0 and no FAULT state is built.
  - PUSH/EXEC on a full stack discards the value; sp stays STACK_DEPTH.
  - Pop on an empty stack yields 0; sp stays 0.
  - JZ on an empty stack treats tos as 0 and branches.

## Structure
- stack_cpu_pkg holds the opcode enum (OP_ADD…OP_JZ) and the state enum (S_START…S_FAULT).
- Sub-module stack_cpu_lifo: register-array stack.
  - Inputs: push, pop, din.
  - Outputs: tos (combinational), sp, full, empty.
  - Parametrised by WIDTH and STACK_DEPTH; asynchronous reset clears sp only.
- The top module contains the FSM, pc, IR, A, B and the ALU.

## Test plan
- Reset mid-run: assert rst during a MEM_RD → mem_req, pc and sp all read 0 in that cycle; fault stays 0.
- Arithmetic, WIDTH=8, zero wait, mem[20]=5, mem[21]=7, program PUSH 20; PUSH 21; SUB; POP 22 → mem[22] written 0xFE; sp ends at 0; SUB takes 5 cycles.
- Wait states: hold mem_ready low for 3 cycles on a fetch at pc=4 → mem_addr stays 4 and pc stays 4 for 3 cycles; pc becomes 5 on the ready edge.
- JZ: with tos=0, JZ 10 → pc=10 and sp unchanged. With tos=3 → pc advances sequentially.
- Overflow, STACK_DEPTH=4, guard enabled: 5 consecutive PUSHes → fault=1 after the 5th DECODE, sp=4, mem_req stays 0 thereafter. With guard disabled: sp=4, fault=0, execution continues.
- Underflow: ADD with sp=1 → fault=1 and sp stays 1. With guard disabled: result = tos+0 is pushed and sp=1.

Source files
------------

// File: rtl/stack_cpu_pkg.sv
// Shared opcode and FSM state encodings for the stack_cpu core.
// Optional build macro used by the core: STACK_CPU_GUARD_EN.
package stack_cpu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOT  = 3'b011,
        OP_PUSH = 3'b100,
        OP_POP  = 3'b101,
        OP_JMP  = 3'b110,
        OP_JZ   = 3'b111
    } op_e;

    typedef enum logic [3:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_POP_A,
        S_POP_B,
        S_EXEC,
        S_MEM_RD,
        S_MEM_WR,
        S_FAULT
    } state_e;

    function automatic logic is_binary(op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/stack_cpu_if.sv
// Unified instruction/data memory port with req/ready wait-state handshake.
interface stack_cpu_if #(
    parameter int WIDTH = 8
);
    localparam int ADDR_W = WIDTH - 3;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_ready;
    logic [WIDTH-1:0]  mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/stack_cpu_lifo.sv
// Register-array stack: push/pop with saturating occupancy and combinational top-of-stack.
module stack_cpu_lifo #(
    parameter  int WIDTH       = 8,
    parameter  int STACK_DEPTH = 16,
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] tos_o,
    output logic [SP_W-1:0]  sp_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d, sp_m1;

    assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
    assign empty_o = (sp_q == '0);
    assign sp_m1   = sp_q - SP_W'(1);
    assign sp_o    = sp_q;
    // An empty stack reads as zero so underflowing pops and JZ see 0.
    assign tos_o   = empty_o ? '0 : mem_q[sp_m1[IDX_W-1:0]];

    // NOTE: default assigned first so no path leaves sp_d unassigned (no latch).
    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_m1;
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // NOTE: storage has no reset; sp_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[sp_q[IDX_W-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/stack_cpu.sv
// Multicycle stack-machine core: FSM, pc, IR, operand registers and ALU.
// Define STACK_CPU_GUARD_EN to build stack overflow/underflow checks and the FAULT state.
module stack_cpu
    import stack_cpu_pkg::*;
#(
    parameter  int WIDTH       = 8,
    parameter  int STACK_DEPTH = 16,
    localparam int ADDR_W      = WIDTH - 3,
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    stack_cpu_if.master       bus,
    output logic              fault,
    output logic [SP_W-1:0]   sp,
    output logic [ADDR_W-1:0] pc
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]  ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  tos, alu_res, push_data;
    logic              push, pop, full, empty;
    op_e               op;
    logic [ADDR_W-1:0] op_addr;

    assign op      = op_e'(ir_q[WIDTH-1 -: 3]);
    assign op_addr = ir_q[ADDR_W-1:0];
    assign pc      = pc_q;

    stack_cpu_lifo #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_data),
        .tos_o   (tos),
        .sp_o    (sp),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        alu_res = ~a_q;
        case (op)
            OP_ADD:  alu_res = b_q + a_q;
            OP_SUB:  alu_res = b_q - a_q;
            OP_AND:  alu_res = b_q & a_q;
            default: alu_res = ~a_q;
        endcase
    end

`ifdef STACK_CPU_GUARD_EN
    logic stack_err;

    always_comb begin
        stack_err = 1'b0;
        if (is_binary(op)) begin
            stack_err = (sp < SP_W'(2));
        end else if (op == OP_NOT || op == OP_POP || op == OP_JZ) begin
            stack_err = empty;
        end else if (op == OP_PUSH) begin
            stack_err = full;
        end
    end

    assign fault = (state_q == S_FAULT);
`else
    logic guard_unused;
    assign guard_unused = full | empty;
    assign fault        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = alu_res;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_JMP:  begin pc_d = op_addr; state_d = S_FETCH; end
                    OP_JZ:   begin
                        if (tos == '0) pc_d = op_addr;
                        state_d = S_FETCH;
                    end
                    OP_PUSH: state_d = S_MEM_RD;
                    default: state_d = S_POP_A;
                endcase
`ifdef STACK_CPU_GUARD_EN
                // The check overrides dispatch so nothing changes but the state.
                if (stack_err) begin
                    pc_d    = pc_q;
                    state_d = S_FAULT;
                end
`endif
            end
            S_POP_A: begin
                a_d = tos;
                pop = 1'b1;
                if (op == OP_POP)      state_d = S_MEM_WR;
                else if (op == OP_NOT) state_d = S_EXEC;
                else                   state_d = S_POP_B;
            end
            S_POP_B: begin
                b_d     = tos;
                pop     = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                push    = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_RD: begin
                if (bus.mem_ready) begin
                    push      = 1'b1;
                    push_data = bus.mem_rdata;
                    state_d   = S_FETCH;
                end
            end
            S_MEM_WR: begin
                if (bus.mem_ready) state_d = S_FETCH;
            end
`ifdef STACK_CPU_GUARD_EN
            S_FAULT: state_d = S_FAULT;
`endif
            default: state_d = S_START;
        endcase
    end

    // Bus outputs decode from registered state, so reset drops mem_req at once.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = pc_q;
            end
            S_MEM_RD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = op_addr;
            end
            S_MEM_WR: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = op_addr;
                bus.mem_wdata = a_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_START;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

endmodule

// File: tb/tb_stack_cpu.sv
// Directed self-checking bench for stack_cpu (WIDTH=8, STACK_DEPTH=4), guard on or off.
module tb_stack_cpu;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = WIDTH - 3;
    localparam int SP_W   = $clog2(DEPTH + 1);
`ifdef STACK_CPU_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              stall = 1'b0;
    logic              fault;
    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] pc;
    logic [WIDTH-1:0]  prog [32];
    int                wr_cnt = 0;
    int                wr_base;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [WIDTH-1:0]  wr_data = '0;
    int                n_checks = 0;
    int                n_err    = 0;

    stack_cpu_if #(.WIDTH(WIDTH)) bus ();

    stack_cpu #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .fault (fault),
        .sp    (sp),
        .pc    (pc)
    );

    always #5 clk = ~clk;

    assign bus.mem_ready = ~stall;
    assign bus.mem_rdata = prog[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus.mem_addr;
            wr_data <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = '0;
    endtask

    initial begin
        // Reset state.
        clear_prog();
        cyc(2);
        check("rst_req",   32'(bus.mem_req),   32'd0);
        check("rst_we",    32'(bus.mem_we),    32'd0);
        check("rst_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_pc",    32'(pc),            32'd0);
        check("rst_sp",    32'(sp),            32'd0);
        check("rst_fault", 32'(fault),         32'd0);

        // PUSH 20; PUSH 21; SUB; POP 22 -> mem[22] = 5 - 7 = 0xFE.
        prog[0] = 8'h94; prog[1] = 8'h95; prog[2] = 8'h20; prog[3] = 8'hB6; prog[4] = 8'hC4;
        prog[20] = 8'd5; prog[21] = 8'd7;
        rst = 1'b0;
        cyc(1);
        check("first_req",  32'(bus.mem_req),  32'd1);
        check("first_addr", 32'(bus.mem_addr), 32'd0);
        cyc(6);
        check("sub_fetch_pc", 32'(pc), 32'd2);
        check("sub_fetch_sp", 32'(sp), 32'd2);
        cyc(4);
        check("sub_exec_req", 32'(bus.mem_req), 32'd0);
        check("sub_exec_sp",  32'(sp),          32'd0);
        cyc(1);
        check("sub_done_req",  32'(bus.mem_req),  32'd1);
        check("sub_done_addr", 32'(bus.mem_addr), 32'd3);
        check("sub_done_sp",   32'(sp),           32'd1);
        cyc(3);
        check("pop_we",    32'(bus.mem_we),    32'd1);
        check("pop_addr",  32'(bus.mem_addr),  32'd22);
        check("pop_wdata", 32'(bus.mem_wdata), 32'hFE);
        cyc(1);
        check("pop_wr_cnt",  32'(wr_cnt),  32'd1);
        check("pop_wr_addr", 32'(wr_addr), 32'd22);
        check("pop_wr_data", 32'(wr_data), 32'hFE);
        check("pop_sp",      32'(sp),      32'd0);
        check("pop_pc",      32'(pc),      32'd4);

        // Asynchronous reset during the second PUSH's MEM_RD.
        rst = 1'b1;
        clear_prog();
        prog[0] = 8'h94; prog[1] = 8'h94; prog[2] = 8'hC2; prog[20] = 8'h11;
        cyc(1);
        rst = 1'b0;
        cyc(6);
        check("mrd_req",  32'(bus.mem_req),  32'd1);
        check("mrd_addr", 32'(bus.mem_addr), 32'd20);
        check("mrd_sp",   32'(sp),           32'd1);
        check("mrd_pc",   32'(pc),           32'd2);
        #1 rst = 1'b1;
        #1;
        check("arst_req",   32'(bus.mem_req), 32'd0);
        check("arst_pc",    32'(pc),          32'd0);
        check("arst_sp",    32'(sp),          32'd0);
        check("arst_fault", 32'(fault),       32'd0);

        // JZ taken on tos=0, not taken on tos=3, then wait states on fetch at pc=4.
        clear_prog();
        prog[0] = 8'h94; prog[1] = 8'hEA; prog[10] = 8'h95; prog[11] = 8'hE4;
        prog[12] = 8'hC4; prog[4] = 8'hC4; prog[20] = 8'd0; prog[21] = 8'd3;
        cyc(1);
        rst = 1'b0;
        cyc(6);
        check("jz_taken_pc", 32'(pc), 32'd10);
        check("jz_taken_sp", 32'(sp), 32'd1);
        cyc(5);
        check("jz_fall_pc", 32'(pc), 32'd12);
        check("jz_fall_sp", 32'(sp), 32'd2);
        cyc(1);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check("wait_addr", 32'(bus.mem_addr), 32'd4);
            check("wait_pc",   32'(pc),           32'd4);
            check("wait_req",  32'(bus.mem_req),  32'd1);
        end
        stall = 1'b0;
        cyc(1);
        check("wait_done_pc", 32'(pc), 32'd5);

        // Five PUSHes into a four-entry stack.
        rst = 1'b1;
        clear_prog();
        for (int i = 0; i < 5; i++) prog[i] = 8'h94;
        prog[5] = 8'hC5; prog[20] = 8'h42;
        cyc(1);
        rst = 1'b0;
        cyc(14);
        check("ovf_dec_pc", 32'(pc), 32'd5);
        check("ovf_dec_sp", 32'(sp), 32'd4);
        cyc(1);
        check("ovf_fault", 32'(fault),       GUARD ? 32'd1 : 32'd0);
        check("ovf_req",   32'(bus.mem_req), GUARD ? 32'd0 : 32'd1);
        check("ovf_sp",    32'(sp),          32'd4);
        cyc(5);
        check("ovf_late_req",   32'(bus.mem_req), GUARD ? 32'd0 : 32'd1);
        check("ovf_late_sp",    32'(sp),          32'd4);
        check("ovf_late_pc",    32'(pc),          32'd5);
        check("ovf_late_fault", 32'(fault),       GUARD ? 32'd1 : 32'd0);

        // ADD with one entry, then POP 23 of whatever was pushed.
        rst = 1'b1;
        clear_prog();
        prog[0] = 8'h94; prog[1] = 8'h00; prog[2] = 8'hB7; prog[3] = 8'hC3; prog[20] = 8'd9;
        wr_base = wr_cnt;
        cyc(1);
        rst = 1'b0;
        cyc(6);
        check("udf_fault", 32'(fault), GUARD ? 32'd1 : 32'd0);
        check("udf_sp",    32'(sp),    32'd1);
        cyc(3);
        check("udf_late_sp",  32'(sp),          32'd1);
        check("udf_late_pc",  32'(pc),          32'd2);
        check("udf_late_req", 32'(bus.mem_req), GUARD ? 32'd0 : 32'd1);
        cyc(4);
        check("udf_wr_cnt", 32'(wr_cnt - wr_base), GUARD ? 32'd0 : 32'd1);
        check("udf_end_sp", 32'(sp),               GUARD ? 32'd1 : 32'd0);
        if (!GUARD) begin
            check("udf_wr_addr", 32'(wr_addr), 32'd23);
            check("udf_wr_data", 32'(wr_data), 32'd9);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
